// File: rtl/alu_enc_pkg.sv
// alu_enc_pkg: ALU op codes, RV32I opcode/funct7 constants and the request-to-word encode function.
package alu_enc_pkg;
    localparam int INSTR_W = 32;
    localparam int OP_W    = 4;
    localparam logic [OP_W-1:0] ALU_AND  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'b1001;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'b1101;
    localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE   = 7'b0010011;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Returns {legal, word}; shift immediates carry funct7 in imm[11:5].
    function automatic logic [INSTR_W:0] alu_encode(input logic [OP_W-1:0] op, input logic use_imm,
                                                    input logic [4:0] rd, input logic [4:0] rs1,
                                                    input logic [4:0] rs2, input logic [11:0] imm);
        logic [2:0] f3;
        logic [6:0] f7;
        logic legal, shift;
        logic [11:0] imm_f;
        f3 = 3'b000;
        f7 = FUNCT7_BASE;
        legal = 1'b1;
        case (op)
            ALU_ADD:  f3 = 3'b000;
            ALU_SUB:  begin f3 = 3'b000; f7 = FUNCT7_ALT; end
            ALU_SLL:  f3 = 3'b001;
            ALU_SLT:  f3 = 3'b010;
            ALU_SLTU: f3 = 3'b011;
            ALU_XOR:  f3 = 3'b100;
            ALU_SRL:  f3 = 3'b101;
            ALU_SRA:  begin f3 = 3'b101; f7 = FUNCT7_ALT; end
            ALU_OR:   f3 = 3'b110;
            ALU_AND:  f3 = 3'b111;
            default:  legal = 1'b0;
        endcase
        shift = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
        if (use_imm && shift && imm[11:5] != 7'd0) legal = 1'b0;
        if (use_imm && op == ALU_SUB) legal = 1'b0;
        imm_f = shift ? {f7, imm[4:0]} : imm;
        return {legal, use_imm ? {imm_f, rs1, f3, rd, OPC_ITYPE} : {f7, rs2, rs1, f3, rd, OPC_RTYPE}};
    endfunction
endpackage

// File: rtl/alu_instr_encoder_if.sv
// alu_instr_encoder_if: request, instruction-out and error signals of the ALU instruction encoder.
interface alu_instr_encoder_if
    import alu_enc_pkg::*;
#(
    parameter int INSTR_WIDTH      = INSTR_W,
    parameter int ALUCONTROL_WIDTH = OP_W,
    parameter int ERRCNT_WIDTH     = 8
);
    logic                        req_valid;
    logic                        req_ready;
    logic [ALUCONTROL_WIDTH-1:0] req_op;
    logic                        req_use_imm;
    logic [4:0]                  req_rd;
    logic [4:0]                  req_rs1;
    logic [4:0]                  req_rs2;
    logic [11:0]                 req_imm;
    logic                        instr_valid;
    logic                        instr_ready;
    logic [INSTR_WIDTH-1:0]      instr;
    logic                        err_pulse;
    logic [ERRCNT_WIDTH-1:0]     err_count;

    modport slave (
        input  req_valid, req_op, req_use_imm, req_rd, req_rs1, req_rs2, req_imm, instr_ready,
        output req_ready, instr_valid, instr, err_pulse, err_count
    );
    modport master (
        output req_valid, req_op, req_use_imm, req_rd, req_rs1, req_rs2, req_imm, instr_ready,
        input  req_ready, instr_valid, instr, err_pulse, err_count
    );
endinterface

// File: rtl/alu_enc_fifo.sv
// alu_enc_fifo: DEPTH x WIDTH synchronous FIFO with occupancy counter and registered full flag.
module alu_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic full_q, do_push, do_pop;

    always_comb begin
        do_push = push_i && !full_q;
        do_pop  = pop_i && cnt_q != '0;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) mem_q[wr_q] <= wdata_i;
            wr_q   <= wr_q + AW'(do_push);
            rd_q   <= rd_q + AW'(do_pop);
            cnt_q  <= cnt_d;
            full_q <= cnt_d == CW'(DEPTH);
        end

    assign rdata_o = mem_q[rd_q];
    assign empty_o = cnt_q == '0;
    assign full_o  = full_q;
endmodule

// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder: ALU request -> RV32I R/I-type word, 2-entry output FIFO, saturating drop counter.
// ALU_ENC_BYPASS_EN: an empty FIFO with a ready consumer passes legal words through the same cycle.
module alu_instr_encoder
    import alu_enc_pkg::*;
#(
    parameter int INSTR_WIDTH  = INSTR_W,
    parameter int FIFO_DEPTH   = 2,
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic clk,
    input  logic reset_n,
    alu_instr_encoder_if.slave bus
);
    logic [INSTR_W:0] enc;
    logic [INSTR_WIDTH-1:0] fifo_word;
    logic fifo_empty, fifo_full, accept, legal, drop, bypass, push, pop;
    logic err_pulse_q;
    logic [ERRCNT_WIDTH-1:0] err_count_q, err_count_d;

    always_comb begin
        enc    = alu_encode(bus.req_op, bus.req_use_imm, bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_imm);
        legal  = enc[INSTR_W];
        accept = bus.req_valid && !fifo_full;
        drop   = accept && !legal;
`ifdef ALU_ENC_BYPASS_EN
        bypass = fifo_empty && accept && legal && bus.instr_ready;
`else
        bypass = 1'b0;
`endif
        push   = accept && legal && !bypass;
        pop    = !fifo_empty && bus.instr_ready;
        err_count_d = (drop && !(&err_count_q)) ? err_count_q + 1'b1 : err_count_q;
    end

    alu_enc_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INSTR_WIDTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (enc[INSTR_WIDTH-1:0]),
        .pop_i   (pop),
        .rdata_o (fifo_word),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= drop;
            err_count_q <= err_count_d;
        end

    assign bus.req_ready   = !fifo_full;
    assign bus.instr_valid = !fifo_empty || bypass;
    assign bus.instr       = bypass ? enc[INSTR_WIDTH-1:0] : fifo_word;
    assign bus.err_pulse   = err_pulse_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_alu_instr_encoder.sv
// tb_alu_instr_encoder: directed and random requests checked against a table-driven encoder and queue model.
module tb_alu_instr_encoder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [31:0] q[$];
    logic [7:0] m_cnt = 8'd0;
    logic m_pulse = 1'b0;

    // {op[3:0], funct3[2:0], alt funct7, is shift}
    localparam logic [8:0] ROWS [10] = '{
        {4'h2, 3'd0, 1'b0, 1'b0}, {4'h6, 3'd0, 1'b1, 1'b0}, {4'h4, 3'd1, 1'b0, 1'b1},
        {4'h8, 3'd2, 1'b0, 1'b0}, {4'h9, 3'd3, 1'b0, 1'b0}, {4'h7, 3'd4, 1'b0, 1'b0},
        {4'h5, 3'd5, 1'b0, 1'b1}, {4'hD, 3'd5, 1'b1, 1'b1}, {4'h3, 3'd6, 1'b0, 1'b0},
        {4'h1, 3'd7, 1'b0, 1'b0}};

    alu_instr_encoder_if bus ();
    alu_instr_encoder dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_enc(input logic [3:0] op, input logic ui, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [11:0] imm, output logic lg);
        logic [8:0] r;
        logic found;
        logic [31:0] f7, immf;
        r = '0;
        found = 1'b0;
        foreach (ROWS[i]) begin
            logic [8:0] row;
            row = ROWS[i];
            if (row[8:5] == op) begin r = row; found = 1'b1; end
        end
        f7 = r[1] ? 32'd32 : 32'd0;
        lg = found && !(ui && r[0] && imm[11:5] != 7'd0) && !(ui && op == 4'h6);
        immf = r[0] ? f7 * 32 + 32'(imm[4:0]) : 32'(imm);
        if (ui)
            return (immf << 20) + (32'(rs1) << 15) + (32'(r[4:2]) << 12) + (32'(rd) << 7) + 32'h13;
        return (f7 << 25) + (32'(rs2) << 20) + (32'(rs1) << 15) + (32'(r[4:2]) << 12) + (32'(rd) << 7) + 32'h33;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs set; checks outputs, then advances one clock and the model.
    task automatic cycle();
        logic [31:0] w;
        logic lg, acc, pop, byp;
        #1;
        w = ref_enc(bus.req_op, bus.req_use_imm, bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_imm, lg);
        acc = bus.req_valid && q.size() < 2;
        byp = 1'b0;
`ifdef ALU_ENC_BYPASS_EN
        byp = acc && lg && bus.instr_ready && q.size() == 0;
`endif
        chk("req_ready", 32'(bus.req_ready), 32'(q.size() < 2));
        chk("instr_valid", 32'(bus.instr_valid), 32'(q.size() > 0 || byp));
        if (byp) chk("instr_bypass", bus.instr, w);
        else if (q.size() > 0) chk("instr_head", bus.instr, q[0]);
        chk("err_pulse", 32'(bus.err_pulse), 32'(m_pulse));
        chk("err_count", 32'(bus.err_count), 32'(m_cnt));
        pop = q.size() > 0 && bus.instr_ready;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        m_pulse = acc && !lg;
        if (acc && !lg && m_cnt != 8'hFF) m_cnt++;
        if (acc && lg && !byp) q.push_back(w);
        @(negedge clk);
    endtask

    task automatic set_req(input logic [3:0] op, input logic ui, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [11:0] imm);
        bus.req_op = op;
        bus.req_use_imm = ui;
        bus.req_rd = rd;
        bus.req_rs1 = rs1;
        bus.req_rs2 = rs2;
        bus.req_imm = imm;
    endtask

    task automatic send(input logic [3:0] op, input logic ui, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [11:0] imm);
        set_req(op, ui, rd, rs1, rs2, imm);
        bus.req_valid = 1'b1;
        cycle();
        bus.req_valid = 1'b0;
    endtask

    task automatic take(input string tag, input logic [31:0] word);
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, "_word"}, bus.instr, word);
        chk({tag, "_nopulse"}, 32'(bus.err_pulse), 32'd0);
        bus.instr_ready = 1'b1;
        cycle();
        bus.instr_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.instr_ready = 1'b0;
        set_req(4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        reset_n = 1'b1;
        cycle();

        send(4'h2, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        take("add", 32'h002081B3);
        send(4'h6, 1'b0, 5'd5, 5'd6, 5'd7, 12'd0);
        take("sub", 32'h407302B3);
        send(4'h2, 1'b1, 5'd1, 5'd0, 5'd0, 12'hFFF);
        take("addi", 32'hFFF00093);
        send(4'hD, 1'b1, 5'd4, 5'd4, 5'd0, 12'h003);
        take("srai", 32'h40325213);
        send(4'hD, 1'b1, 5'd4, 5'd4, 5'd0, 12'h023);
        chk("srai_bad_pulse", 32'(bus.err_pulse), 32'd1);
        chk("srai_bad_count", 32'(bus.err_count), 32'd1);
        chk("srai_bad_valid", 32'(bus.instr_valid), 32'd0);
        send(4'h6, 1'b1, 5'd2, 5'd3, 5'd0, 12'h001);
        chk("subi_pulse", 32'(bus.err_pulse), 32'd1);
        cycle();

        bus.req_valid = 1'b1;
        set_req(4'h2, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        cycle();
        set_req(4'h6, 1'b0, 5'd5, 5'd6, 5'd7, 12'd0);
        cycle();
        set_req(4'h7, 1'b0, 5'd9, 5'd10, 5'd11, 12'd0);
        cycle();
        cycle();
        chk("full_req_ready", 32'(bus.req_ready), 32'd0);
        chk("full_head", bus.instr, 32'h002081B3);
        bus.req_valid = 1'b0;
        bus.instr_ready = 1'b1;
        cycle();
        chk("ready_back", 32'(bus.req_ready), 32'd1);
        chk("second_head", bus.instr, 32'h407302B3);
        repeat (3) cycle();

        for (int n = 0; n < 400; n++) begin
            logic [8:0] row;
            row = ROWS[$urandom_range(0, 9)];
            set_req(($urandom_range(0, 7) == 0) ? 4'($urandom) : row[8:5], 1'($urandom),
                    5'($urandom), 5'($urandom), 5'($urandom),
                    ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 31)));
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.instr_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        bus.req_valid = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (3) cycle();

        bus.req_valid = 1'b1;
        set_req(4'hF, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0);
        repeat (300) cycle();
        bus.req_valid = 1'b0;
        cycle();
        chk("err_saturated", 32'(bus.err_count), 32'hFF);

        bus.instr_ready = 1'b0;
        send(4'h2, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        send(4'h3, 1'b0, 5'd8, 5'd9, 5'd10, 12'd0);
        chk("pre_rst_full", 32'(bus.req_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("mid_rst_count", 32'(bus.err_count), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        q.delete();
        m_cnt = 8'd0;
        m_pulse = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.instr_ready = 1'b1;
        cycle();

`ifdef ALU_ENC_BYPASS_EN
        set_req(4'h2, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        bus.req_valid = 1'b1;
        #1;
        chk("bypass_valid", 32'(bus.instr_valid), 32'd1);
        chk("bypass_word", bus.instr, 32'h002081B3);
        cycle();
        bus.req_valid = 1'b0;
        cycle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
